// File: rtl/dm_cache_pkg.sv
// Shared types and address-split helpers for the direct-mapped line cache.
package dm_cache_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOOKUP  = 3'd1,
    MREQ    = 3'd2,
    REFILL  = 3'd3,
    RESPOND = 3'd4
  } state_t;

  // Byte-offset bits covering one whole line
  function automatic int off_w(input int data_w, input int beats);
    return $clog2(beats * data_w / 8);
  endfunction

  // Set-index bits
  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction

  // Remaining upper address bits form the tag
  function automatic int tag_w(input int data_w, input int beats, input int sets);
    return data_w - off_w(data_w, beats) - idx_w(sets);
  endfunction

endpackage

// File: rtl/dm_cache_data_ram.sv
// Line data storage: one write port, asynchronous read, addressed by (set, beat).
module dm_cache_data_ram #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int NUM_SETS       = 64,
  parameter int LINE_BEATS     = 8,
  parameter int IDX_W          = $clog2(NUM_SETS),
  parameter int BEAT_W         = $clog2(LINE_BEATS)
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [IDX_W-1:0]          w_idx,
  input  logic [BEAT_W-1:0]         w_beat,
  input  logic [BUS_DATA_WIDTH-1:0] w_data,
  input  logic [IDX_W-1:0]          r_idx,
  input  logic [BEAT_W-1:0]         r_beat,
  output logic [BUS_DATA_WIDTH-1:0] r_data
);

  logic [BUS_DATA_WIDTH-1:0] mem [NUM_SETS*LINE_BEATS];

  // Write one refill beat into its slot
  always_ff @(posedge clk) begin
    if (we) mem[{w_idx, w_beat}] <= w_data;
  end

  assign r_data = mem[{r_idx, r_beat}];

endmodule

// File: rtl/dm_line_cache.sv
// Direct-mapped read-only line cache between processor and DRAM Sysbus ports.
module dm_line_cache
  import dm_cache_pkg::*;
#(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int NUM_SETS       = 64,
  parameter int LINE_BEATS     = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      p_bus_reqcyc,
  output logic                      p_bus_reqack,
  input  logic [BUS_DATA_WIDTH-1:0] p_bus_req,
  input  logic [BUS_TAG_WIDTH-1:0]  p_bus_reqtag,
  output logic                      p_bus_respcyc,
  input  logic                      p_bus_respack,
  output logic [BUS_DATA_WIDTH-1:0] p_bus_resp,
  output logic [BUS_TAG_WIDTH-1:0]  p_bus_resptag,
  output logic                      m_bus_reqcyc,
  input  logic                      m_bus_reqack,
  output logic [BUS_DATA_WIDTH-1:0] m_bus_req,
  output logic [BUS_TAG_WIDTH-1:0]  m_bus_reqtag,
  input  logic                      m_bus_respcyc,
  output logic                      m_bus_respack,
  input  logic [BUS_DATA_WIDTH-1:0] m_bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]  m_bus_resptag,
  input  logic                      inval_all
);

  localparam int OFF_W  = off_w(BUS_DATA_WIDTH, LINE_BEATS);
  localparam int IDX_W  = idx_w(NUM_SETS);
  localparam int TAG_W  = tag_w(BUS_DATA_WIDTH, LINE_BEATS, NUM_SETS);
  localparam int BEAT_W = $clog2(LINE_BEATS);
  localparam int LINE_W = BUS_DATA_WIDTH - OFF_W;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_BEATS - 1);

  state_t                    state, state_nxt;
  logic [LINE_W-1:0]         line_q;
  logic [BUS_TAG_WIDTH-1:0]  tag_q;
  logic [NUM_SETS-1:0]       valid;
  logic [TAG_W-1:0]          tag_arr [NUM_SETS];
  logic                      inval_pend;
  logic [BEAT_W-1:0]         ptr;
  logic [BUS_DATA_WIDTH-1:0] rd_data;

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] atag;
  logic             hit, accept, last_ptr, refill_beat, refill_done, resp_beat;

  assign idx         = line_q[IDX_W-1:0];
  assign atag        = line_q[LINE_W-1 -: TAG_W];
  assign hit         = valid[idx] && (tag_arr[idx] == atag);
  assign accept      = (state == IDLE) && p_bus_reqcyc && !inval_pend && !reset;
  assign last_ptr    = (ptr == LAST_BEAT);
  assign refill_beat = (state == REFILL) && m_bus_respcyc;
  assign refill_done = refill_beat && last_ptr;
  assign resp_beat   = (state == RESPOND) && p_bus_respack;

  // Offset bits of the request and the DRAM beat tag carry no information here
  logic unused_ok;
  assign unused_ok = &{1'b0, p_bus_req[OFF_W-1:0], m_bus_resptag};

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)                    state_nxt = LOOKUP;
      LOOKUP:  state_nxt = hit ? RESPOND : MREQ;
      MREQ:    if (m_bus_reqack)              state_nxt = REFILL;
      REFILL:  if (refill_done)               state_nxt = RESPOND;
      RESPOND: if (resp_beat && last_ptr)     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode; everything idles at zero outside its owning state
  always_comb begin
    p_bus_reqack  = accept;
    p_bus_respcyc = 1'b0;
    p_bus_resp    = '0;
    p_bus_resptag = '0;
    m_bus_reqcyc  = 1'b0;
    m_bus_req     = '0;
    m_bus_reqtag  = '0;
    m_bus_respack = 1'b0;
    case (state)
      MREQ: begin
        m_bus_reqcyc = 1'b1;
        m_bus_req    = {line_q, {OFF_W{1'b0}}};
        m_bus_reqtag = tag_q;
      end
      REFILL:  m_bus_respack = m_bus_respcyc;
      RESPOND: begin
        p_bus_respcyc = 1'b1;
        p_bus_resp    = rd_data;
        p_bus_resptag = tag_q;
      end
      default: ;
    endcase
  end

  // Control state: beat pointer, valid bits, pending bulk invalidate
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr        <= '0;
      valid      <= '0;
      inval_pend <= 1'b0;
    end else begin
      if (state == LOOKUP || state == MREQ) ptr <= '0;
      else if (refill_beat || resp_beat)    ptr <= ptr + 1'b1;

      // A late refill would otherwise revive a line an invalidate just hit
      if (state == IDLE && inval_pend)      valid      <= '0;
      else if (refill_done && !inval_all)   valid[idx] <= 1'b1;

      if (inval_all)          inval_pend <= 1'b1;
      else if (state == IDLE) inval_pend <= 1'b0;
    end
  end

  // Request latch and tag array; contents are meaningless until a valid bit says otherwise
  always_ff @(posedge clk) begin
    if (accept) begin
      line_q <= p_bus_req[BUS_DATA_WIDTH-1:OFF_W];
      tag_q  <= p_bus_reqtag;
    end
    if (refill_done) tag_arr[idx] <= atag;
  end

  dm_cache_data_ram #(
    .BUS_DATA_WIDTH(BUS_DATA_WIDTH),
    .NUM_SETS      (NUM_SETS),
    .LINE_BEATS    (LINE_BEATS),
    .IDX_W         (IDX_W),
    .BEAT_W        (BEAT_W)
  ) u_data_ram (
    .clk   (clk),
    .we    (refill_beat),
    .w_idx (idx),
    .w_beat(ptr),
    .w_data(m_bus_resp),
    .r_idx (idx),
    .r_beat(ptr),
    .r_data(rd_data)
  );

endmodule

// File: tb/tb_dm_line_cache.sv
// Randomised scoreboard bench for dm_line_cache with a set-level reference model.
module tb_dm_line_cache;

  localparam int DW = 64, TW = 13, SETS = 64, BEATS = 8;

  logic          clk = 1'b0, reset = 1'b1;
  logic          p_bus_reqcyc = 1'b0, p_bus_reqack;
  logic [DW-1:0] p_bus_req = '0;
  logic [TW-1:0] p_bus_reqtag = '0;
  logic          p_bus_respcyc, p_bus_respack = 1'b0;
  logic [DW-1:0] p_bus_resp;
  logic [TW-1:0] p_bus_resptag;
  logic          m_bus_reqcyc, m_bus_reqack = 1'b0;
  logic [DW-1:0] m_bus_req;
  logic [TW-1:0] m_bus_reqtag;
  logic          m_bus_respcyc = 1'b0, m_bus_respack;
  logic [DW-1:0] m_bus_resp = '0;
  logic [TW-1:0] m_bus_resptag = '0;
  logic          inval_all = 1'b0;

  dm_line_cache #(.BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW), .NUM_SETS(SETS), .LINE_BEATS(BEATS)) dut (
    .clk(clk), .reset(reset),
    .p_bus_reqcyc(p_bus_reqcyc), .p_bus_reqack(p_bus_reqack), .p_bus_req(p_bus_req),
    .p_bus_reqtag(p_bus_reqtag), .p_bus_respcyc(p_bus_respcyc), .p_bus_respack(p_bus_respack),
    .p_bus_resp(p_bus_resp), .p_bus_resptag(p_bus_resptag),
    .m_bus_reqcyc(m_bus_reqcyc), .m_bus_reqack(m_bus_reqack), .m_bus_req(m_bus_req),
    .m_bus_reqtag(m_bus_reqtag), .m_bus_respcyc(m_bus_respcyc), .m_bus_respack(m_bus_respack),
    .m_bus_resp(m_bus_resp), .m_bus_resptag(m_bus_resptag), .inval_all(inval_all)
  );

  initial forever #5 clk = ~clk;

  int errors = 0, checks = 0;

  typedef struct { logic [DW-1:0] d; logic [TW-1:0] t; } item_t;
  item_t resp_q[$];
  item_t mreq_q[$];

  // Reference model: per-set "which line is resident", plus DRAM fetch generations
  bit            mv    [SETS];
  logic [DW-1:0] mline [SETS];
  int            mcnt  [SETS];
  int            fc_model [logic [DW-1:0]];
  int            fc_dram  [logic [DW-1:0]];

  // Knobs shared between driver and responders
  bit rand_stall = 0;
  int dly_knob = 0;
  int stall_beat = -1, stall_left = 0;
  int beat_in_line = 0;

  // DRAM contents change with every fetch of a line so a wrong hit/miss shows in data
  function automatic logic [DW-1:0] dram_word(input logic [DW-1:0] line, input int cnt, input int b);
    logic [15:0] c16 = 16'(cnt);
    logic [7:0]  b8  = 8'(b);
    if (line == 64'h1040 && cnt == 0) return 64'hA0 + 64'(b);
    return {line[31:0], c16, 8'h5A, b8};
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_to(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting (got none, expected event)", name);
  endtask

  task automatic model_clear();
    for (int i = 0; i < SETS; i++) mv[i] = 0;
  endtask

  // Processor-side response monitor: compare every presented beat, pop on handshake
  initial forever begin
    @(negedge clk);
    if (reset) beat_in_line = 0;
    else if (p_bus_respcyc) begin
      if (resp_q.size() == 0) chk("resp_unexpected", {63'd0, p_bus_respcyc}, 64'd0);
      else begin
        chk("resp_data", p_bus_resp, resp_q[0].d);
        chk("resp_tag", 64'(p_bus_resptag), 64'(resp_q[0].t));
        if (p_bus_respack) begin
          void'(resp_q.pop_front());
          beat_in_line = (beat_in_line + 1) % BEATS;
        end
      end
    end
  end

  // DRAM-side request monitor: request must hold stable until accepted
  initial forever begin
    @(negedge clk);
    if (!reset && m_bus_reqcyc) begin
      if (mreq_q.size() == 0) chk("mreq_unexpected", {63'd0, m_bus_reqcyc}, 64'd0);
      else begin
        chk("mreq_addr", m_bus_req, mreq_q[0].d);
        chk("mreq_tag", 64'(m_bus_reqtag), 64'(mreq_q[0].t));
        if (m_bus_reqack) void'(mreq_q.pop_front());
      end
    end
    if (!reset && m_bus_respcyc && !m_bus_respack) chk("m_respack", 64'(m_bus_respack), 64'd1);
  end

  // Processor respack driver with optional directed stall
  initial forever begin
    @(posedge clk); #1;
    if (stall_left > 0 && p_bus_respcyc && beat_in_line == stall_beat) begin
      p_bus_respack = 1'b0;
      stall_left--;
    end else if (rand_stall) p_bus_respack = ($urandom_range(0, 2) != 0);
    else p_bus_respack = 1'b1;
  end

  // DRAM responder
  initial forever begin
    logic [DW-1:0] line;
    int cnt, dly;
    @(posedge clk); #1;
    m_bus_reqack = 1'b0;
    m_bus_respcyc = 1'b0;
    if (reset || !m_bus_reqcyc) continue;
    dly = (dly_knob < 0) ? $urandom_range(0, 3) : dly_knob;
    repeat (dly) begin @(posedge clk); #1; end
    if (reset) continue;
    line = m_bus_req;
    m_bus_reqack = 1'b1;
    @(posedge clk); #1;
    m_bus_reqack = 1'b0;
    cnt = fc_dram.exists(line) ? fc_dram[line] : 0;
    fc_dram[line] = cnt + 1;
    for (int b = 0; b < BEATS; b++) begin
      int gap = rand_stall ? $urandom_range(0, 2) : 0;
      repeat (gap) begin @(posedge clk); #1; end
      m_bus_respcyc = 1'b1;
      m_bus_resp    = dram_word(line, cnt, b);
      m_bus_resptag = TW'(b);
      @(posedge clk); #1;
      m_bus_respcyc = 1'b0;
    end
  end

  // Predict outcome, queue expectations, then present the request until accepted
  task automatic req_issue(input logic [DW-1:0] addr, input logic [TW-1:0] tag, input bit inval_mid);
    logic [DW-1:0] line;
    int idx, n;
    bit hit, acked;
    line = addr & ~64'h3F;
    idx  = int'((addr >> 6) & 64'(SETS - 1));
    hit  = mv[idx] && (mline[idx] == line);
    if (!hit) begin
      int c = fc_model.exists(line) ? fc_model[line] : 0;
      fc_model[line] = c + 1;
      mreq_q.push_back('{line, tag});
      mv[idx] = 1; mline[idx] = line; mcnt[idx] = c;
    end
    for (int b = 0; b < BEATS; b++) resp_q.push_back('{dram_word(line, mcnt[idx], b), tag});
    if (inval_mid) model_clear();

    @(posedge clk); #1;
    p_bus_reqcyc = 1'b1; p_bus_req = addr; p_bus_reqtag = tag;
    acked = 0; n = 0;
    while (!acked && n < 50) begin
      @(negedge clk);
      acked = p_bus_reqack;
      n++;
    end
    if (!acked) fail_to("req_accept");
    @(posedge clk); #1;
    p_bus_reqcyc = 1'b0;
    chk("lookup_quiet", {62'd0, p_bus_respcyc, m_bus_reqcyc}, 64'd0);
    @(posedge clk); #1;
    if (hit) chk("hit_latency", 64'(p_bus_respcyc), 64'd1);
    else     chk("miss_latency", 64'(m_bus_reqcyc), 64'd1);
    if (inval_mid) begin
      if (!hit) begin
        n = 0;
        while (!m_bus_respack && n < 100) begin @(posedge clk); #2; n++; end
        if (!m_bus_respack) fail_to("refill_start");
      end
      inval_all = 1'b1;
      @(posedge clk); #1;
      inval_all = 1'b0;
    end
  endtask

  task automatic req_wait();
    int n = 0;
    while (resp_q.size() != 0 && n < 500) begin @(negedge clk); n++; end
    if (resp_q.size() != 0) fail_to("resp_drain");
  endtask

  task automatic do_req(input logic [DW-1:0] addr, input logic [TW-1:0] tag, input bit inval_mid);
    req_issue(addr, tag, inval_mid);
    req_wait();
  endtask

  task automatic chk_outputs_zero(input string pfx);
    chk({pfx, "_reqack"},  64'(p_bus_reqack), 64'd0);
    chk({pfx, "_respcyc"}, 64'(p_bus_respcyc), 64'd0);
    chk({pfx, "_resp"},    p_bus_resp, 64'd0);
    chk({pfx, "_resptag"}, 64'(p_bus_resptag), 64'd0);
    chk({pfx, "_mreqcyc"}, 64'(m_bus_reqcyc), 64'd0);
    chk({pfx, "_mreq"},    m_bus_req, 64'd0);
    chk({pfx, "_mreqtag"}, 64'(m_bus_reqtag), 64'd0);
    chk({pfx, "_mrespack"}, 64'(m_bus_respack), 64'd0);
  endtask

  initial begin
    model_clear();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk_outputs_zero("reset");

    // Cold miss, then hit on another offset of the same line
    do_req(64'h1040, 13'd5, 0);
    do_req(64'h1058, 13'd6, 0);

    // Conflict in set 1 evicts, and the original line misses again
    do_req(64'h2040, 13'd7, 0);
    do_req(64'h1040, 13'd8, 0);

    // Slow DRAM accept and a processor stall on beat 2
    dly_knob = 5; stall_beat = 2; stall_left = 3;
    do_req(64'h3000, 13'd9, 0);
    dly_knob = 0; stall_beat = -1;

    // Invalidate during a refill; the previously resident line must miss afterwards
    do_req(64'h4080, 13'd10, 1);
    do_req(64'h1040, 13'd11, 0);

    // Reset while beat 4 of a hit is on the bus
    req_issue(64'h1040, 13'd12, 0);
    begin
      int n = 0;
      while (!(p_bus_respcyc && beat_in_line == 4) && n < 100) begin @(posedge clk); #1; n++; end
      if (n >= 100) fail_to("beat4_reach");
    end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_outputs_zero("midreset");
    resp_q.delete();
    mreq_q.delete();
    model_clear();
    @(posedge clk); #1 reset = 1'b0;
    do_req(64'h1040, 13'd13, 0);

    // Randomised traffic over a small pool of sets and tags
    rand_stall = 1; dly_knob = -1;
    for (int i = 0; i < 40; i++) begin
      logic [DW-1:0] a;
      a = (64'($urandom_range(1, 3)) << 12) | (64'($urandom_range(0, 3)) << 6) | 64'($urandom_range(0, 63));
      do_req(a, TW'($urandom), $urandom_range(0, 7) == 0);
      if ($urandom_range(0, 9) == 0) begin
        @(posedge clk); #1 inval_all = 1'b1;
        model_clear();
        @(posedge clk); #1 inval_all = 1'b0;
      end
    end

    repeat (5) @(posedge clk);
    chk("resp_q_left", 64'(resp_q.size()), 64'd0);
    chk("mreq_q_left", 64'(mreq_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (got timeout, expected completion)");
    $fatal(1);
  end

endmodule
